word_narrower: RTL and testbench
================================

WORD_NARROWER -- requirements
Module: word_narrower

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, listed first as follows.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  X_in/ZE_SE present
- in_ready  output  1  module accepts a word this cycle
- X_in  input  32  word to narrow
- ZE_SE  input  1  0 = zero-extension rule, 1 = sign-extension rule
- out_valid  output  1  X_out/fits present
- out_ready  input  1  consumer takes the head word this cycle
- X_out  output  16  narrowed halfword
- fits  output  1  1 = X_in was exactly representable under the rule
- ovf_cnt  output  8  count of accepted non-fitting words, saturating
- ovf_sticky  output  1  set by any accepted non-fitting word
- clr_ovf  input  1  clear ovf_cnt and ovf_sticky

Function
REQ-002 Accept = in_valid && in_ready at a rising clk edge; Pop = out_valid && out_ready at a rising clk edge.
REQ-003 The fit check SHALL be: ZE_SE=0 -> X_in[31:16]==16'h0000; ZE_SE=1 -> X_in[31:16] all equal to X_in[15].
REQ-004 Accepted words SHALL enter a 2-entry FIFO holding {X_out, fits}; ZE_SE and X_in are sampled only at Accept.
REQ-005 in_ready SHALL be a registered signal equal to (occupancy < 2), so Accept is never offered when full.
REQ-006 out_valid SHALL equal (occupancy > 0); X_out/fits SHALL show the head entry and stay stable until Pop.
REQ-007 Latency: a word accepted into an empty FIFO SHALL show out_valid=1 in the next cycle.
REQ-008 Simultaneous Accept and Pop SHALL leave occupancy unchanged and preserve order.
REQ-009 Pop on an empty FIFO is impossible by construction; out_ready with out_valid=0 SHALL have no effect.
REQ-010 Throughput: with out_ready held at 1, one word per cycle SHALL be sustained.
REQ-011 On Accept of a non-fitting word, ovf_cnt SHALL increment, saturating at 8'hFF, and ovf_sticky SHALL set.
REQ-012 If clr_ovf coincides with Accept of a non-fitting word, the result SHALL be ovf_cnt=1 and ovf_sticky=1; otherwise clr_ovf SHALL give ovf_cnt=0 and ovf_sticky=0.
REQ-013 A fitting word SHALL leave ovf_cnt and ovf_sticky unchanged.

Reset
REQ-014 In the cycle after rst=1: occupancy=0, out_valid=0, in_ready=1, X_out=16'h0000, fits=0, ovf_cnt=0, ovf_sticky=0.
REQ-015 rst SHALL override Accept, Pop and clr_ovf in the same cycle, and all in-flight entries SHALL be discarded.

Configuration
REQ-016 The macro NARROW_SAT_EN SHALL select saturation of non-fitting words.
REQ-017 Without NARROW_SAT_EN: X_out = X_in[15:0] (truncation) for all words.
REQ-018 With NARROW_SAT_EN, for non-fitting words:
- ZE_SE=0 -> X_out = 16'hFFFF
- ZE_SE=1 -> X_out = 16'h8000 if X_in[31]=1, else 16'h7FFF
REQ-019 Fitting words, fits, the counters and the handshake SHALL be identical in both builds.

Verification
REQ-020 The bench SHALL cover the following directed scenarios.
- ZE_SE=0, X_in=32'h0000_1234 -> next cycle X_out=16'h1234, fits=1, ovf_cnt=0.
- ZE_SE=1, X_in=32'hFFFF_8001 -> fits=1, X_out=16'h8001. ZE_SE=1, X_in=32'h0000_8001 -> fits=0, ovf_cnt=1, X_out=16'h8001 (no macro) or 16'h7FFF (NARROW_SAT_EN).
- out_ready=0 with 3 words offered -> in_ready=0 after 2 Accepts; releasing out_ready yields the words in order with no loss or duplication.
- 300 non-fitting Accepts -> ovf_cnt=8'hFF and ovf_sticky=1; clr_ovf with a non-fitting Accept in the same cycle -> ovf_cnt=1.
- rst asserted with 2 entries queued and clr_ovf=1 -> next cycle out_valid=0, in_ready=1, ovf_cnt=0.
- out_ready=1 with a back-to-back stream of 8 words -> 8 outputs on consecutive cycles, with in_ready held at 1.

Source files
------------

// File: rtl/word_narrower.sv
// Narrows 32-bit words to 16 bits through a 2-entry FIFO, flagging and counting words that do not fit.
// Optional build macro NARROW_SAT_EN: saturate non-fitting words instead of truncating them.
module word_narrower (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] X_in,
  input  logic        ZE_SE,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] X_out,
  output logic        fits,
  output logic [7:0]  ovf_cnt,
  output logic        ovf_sticky,
  input  logic        clr_ovf
);

  localparam int unsigned IN_W  = 32;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned OCC_W = 2;

  typedef struct packed {
    logic [OUT_W-1:0] x;
    logic             fits;
  } entry_t;

  entry_t             head_q, head_d;
  entry_t             tail_q, tail_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
  logic               ovf_sticky_q, ovf_sticky_d;

  logic               push;
  logic               pop;
  logic               fit_c;
  logic [OUT_W-1:0]   narrow_c;
  entry_t             new_entry;

  // Fit check and narrowing of the incoming word
  always_comb begin
    fit_c    = 1'b0;
    narrow_c = X_in[OUT_W-1:0];
    if (ZE_SE) begin
      fit_c = (X_in[IN_W-1:OUT_W] == {OUT_W{X_in[OUT_W-1]}});
    end else begin
      fit_c = (X_in[IN_W-1:OUT_W] == '0);
    end
`ifdef NARROW_SAT_EN
    if (!fit_c) begin
      if (ZE_SE) begin
        narrow_c = X_in[IN_W-1] ? 16'h8000 : 16'h7FFF;
      end else begin
        narrow_c = 16'hFFFF;
      end
    end
`endif
    new_entry.x    = narrow_c;
    new_entry.fits = fit_c;
  end

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // Shift-style FIFO: head entry drives the outputs directly
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    occ_d        = occ_q;
    ovf_cnt_d    = ovf_cnt_q;
    ovf_sticky_d = ovf_sticky_q;

    if (push && pop) begin
      if (occ_q == 2'd2) begin
        head_d = tail_q;
        tail_d = new_entry;
      end else begin
        head_d = new_entry;
      end
    end else if (push) begin
      if (occ_q == 2'd0) begin
        head_d = new_entry;
      end else begin
        tail_d = new_entry;
      end
      occ_d = occ_q + 2'd1;
    end else if (pop) begin
      if (occ_q == 2'd2) begin
        head_d = tail_q;
      end
      occ_d = occ_q - 2'd1;
    end

    // A non-fitting accept wins over a same-cycle clear, counting from zero
    if (push && !fit_c) begin
      ovf_sticky_d = 1'b1;
      if (clr_ovf) begin
        ovf_cnt_d = CNT_W'(1);
      end else if (ovf_cnt_q != {CNT_W{1'b1}}) begin
        ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      end
    end else if (clr_ovf) begin
      ovf_cnt_d    = '0;
      ovf_sticky_d = 1'b0;
    end

    in_ready_d  = (occ_d != 2'd2);
    out_valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      occ_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      ovf_cnt_q    <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      occ_q        <= occ_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      ovf_cnt_q    <= ovf_cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign X_out      = head_q.x;
  assign fits       = head_q.fits;
  assign ovf_cnt    = ovf_cnt_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_word_narrower.sv
// Directed, table-driven bench for word_narrower (expectations follow NARROW_SAT_EN when defined).
module tb_word_narrower;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X_in;
  logic        ZE_SE;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] X_out;
  logic        fits;
  logic [7:0]  ovf_cnt;
  logic        ovf_sticky;
  logic        clr_ovf;

  int errors = 0;
  int checks = 0;

  word_narrower dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .X_in(X_in), .ZE_SE(ZE_SE),
    .out_valid(out_valid), .out_ready(out_ready),
    .X_out(X_out), .fits(fits),
    .ovf_cnt(ovf_cnt), .ovf_sticky(ovf_sticky),
    .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ze;
    logic [31:0] x;
    logic [15:0] exp_trunc;
    logic [15:0] exp_sat;
    logic        exp_fits;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_x;

    vecs[0] = '{1'b0, 32'h0000_1234, 16'h1234, 16'h1234, 1'b1, 8'd0};
    vecs[1] = '{1'b1, 32'hFFFF_8001, 16'h8001, 16'h8001, 1'b1, 8'd0};
    vecs[2] = '{1'b1, 32'h0000_8001, 16'h8001, 16'h7FFF, 1'b0, 8'd1};
    vecs[3] = '{1'b0, 32'h0001_0000, 16'h0000, 16'hFFFF, 1'b0, 8'd2};
    vecs[4] = '{1'b1, 32'h8000_0000, 16'h0000, 16'h8000, 1'b0, 8'd3};
    vecs[5] = '{1'b1, 32'h0000_7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 8'd3};
    vecs[6] = '{1'b0, 32'h0000_FFFF, 16'hFFFF, 16'hFFFF, 1'b1, 8'd3};
    vecs[7] = '{1'b1, 32'hFFFF_7FFF, 16'h7FFF, 16'h8000, 1'b0, 8'd4};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 1'b0, 8'd5};
    vecs[9] = '{1'b1, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 1'b1, 8'd5};

    rst = 1'b1; in_valid = 1'b0; X_in = '0; ZE_SE = 1'b0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_x_out", 32'(X_out), 32'h0);
    chk("rst_fits", 32'(fits), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
    rst = 1'b0;

    // Table: one word in, check head one cycle later, then pop it
    for (int i = 0; i < 10; i++) begin
`ifdef NARROW_SAT_EN
      exp_x = vecs[i].exp_sat;
`else
      exp_x = vecs[i].exp_trunc;
`endif
      in_valid = 1'b1; X_in = vecs[i].x; ZE_SE = vecs[i].ze; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_x_out", i), 32'(X_out), 32'(exp_x));
      chk($sformatf("vec%0d_fits", i), 32'(fits), 32'(vecs[i].exp_fits));
      chk($sformatf("vec%0d_ovf_cnt", i), 32'(ovf_cnt), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_sticky", i), 32'(ovf_sticky), 32'(vecs[i].exp_cnt != 8'd0));
      out_ready = 1'b1;
      step();
      chk($sformatf("vec%0d_popped", i), 32'(out_valid), 32'd0);
      out_ready = 1'b0;
    end

    // Backpressure: 3 words offered with out_ready low
    ZE_SE = 1'b0; in_valid = 1'b1; X_in = 32'h0000_0011;
    step();
    chk("bp_ready_after1", 32'(in_ready), 32'd1);
    X_in = 32'h0000_0022;
    step();
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_head_a", 32'(X_out), 32'h0011);
    X_in = 32'h0000_0033;
    step();
    chk("bp_ready_held", 32'(in_ready), 32'd0);
    chk("bp_head_stable", 32'(X_out), 32'h0011);
    out_ready = 1'b1;
    step();
    chk("bp_head_b", 32'(X_out), 32'h0022);
    chk("bp_valid_b", 32'(out_valid), 32'd1);
    chk("bp_ready_reopen", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_head_c", 32'(X_out), 32'h0033);
    chk("bp_valid_c", 32'(out_valid), 32'd1);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Saturating counter: 300 non-fitting accepts while streaming
    in_valid = 1'b1; ZE_SE = 1'b0; X_in = 32'h0001_0000; out_ready = 1'b1;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    chk("sat_ovf_cnt", 32'(ovf_cnt), 32'hFF);
    chk("sat_sticky", 32'(ovf_sticky), 32'd1);
    step();
    in_valid = 1'b1; clr_ovf = 1'b1;
    step();
    in_valid = 1'b0;
    chk("clr_with_ovf_cnt", 32'(ovf_cnt), 32'd1);
    chk("clr_with_ovf_sticky", 32'(ovf_sticky), 32'd1);
    step();
    clr_ovf = 1'b0;
    chk("clr_cnt", 32'(ovf_cnt), 32'd0);
    chk("clr_sticky", 32'(ovf_sticky), 32'd0);
    in_valid = 1'b1; X_in = 32'h0000_5555;
    step();
    in_valid = 1'b0;
    chk("fit_keeps_cnt", 32'(ovf_cnt), 32'd0);
    chk("fit_keeps_sticky", 32'(ovf_sticky), 32'd0);
    step();

    // Reset with two queued entries and clr_ovf
    out_ready = 1'b0; in_valid = 1'b1; X_in = 32'h0002_0000;
    step();
    step();
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    chk("pre_rst_cnt", 32'(ovf_cnt), 32'd2);
    rst = 1'b1; clr_ovf = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; clr_ovf = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("rst_q_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q_in_ready", 32'(in_ready), 32'd1);
    chk("rst_q_ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("rst_q_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_q_x_out", 32'(X_out), 32'h0);
    step();
    chk("rst_q_still_empty", 32'(out_valid), 32'd0);

    // Back-to-back stream of 8 words with out_ready held high
    out_ready = 1'b1; ZE_SE = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; X_in = 32'h0000_00A0 + 32'(k);
      step();
      chk($sformatf("stream%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d_x_out", k), 32'(X_out), 32'h00A0 + 32'(k));
      chk($sformatf("stream%0d_in_ready", k), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
